dtfag_addr_gen: RTL and testbench

Upstream neighbour of the DTFAG multiply stage for the radix-16, 65536-point BFFTP.
- Walks the group index of one FFT stage.
- Forms two twiddle exponents per group and splits each into high-half/low-half ROM addresses for ROM0 bank 0 and bank 1.
- Delays the four data words by the ROM read latency, so that ROM outputs and data arrive at the multiply stage in the same cycle.

---
 rtl/dtfag_pkg.sv | 22 ++
 rtl/dtfag_addr_gen_if.sv | 35 +++
 rtl/dtfag_delay_pipe.sv | 26 ++
 rtl/dtfag_addr_gen.sv | 135 +++++++++++++
 tb/tb_dtfag_addr_gen.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/dtfag_pkg.sv
// Shared types, widths and helpers for the DTFAG address generator.
package dtfag_pkg;

  localparam int unsigned LOG_N   = 16;
  localparam int unsigned ADDR_W  = LOG_N / 2;
  localparam int unsigned DIGIT_W = 4;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} fsm_t;

  typedef logic [LOG_N-1:0] exp_t;

  // Radix-16 digit reversal of the low ndig digits; upper digits come back zero.
  function automatic exp_t digit_rev(input exp_t j, input int unsigned ndig);
    exp_t r;
    r = '0;
    for (int unsigned d = 0; d < LOG_N / DIGIT_W; d++) begin
      if (d < ndig) r[DIGIT_W*(ndig-1-d) +: DIGIT_W] = j[DIGIT_W*d +: DIGIT_W];
    end
    return r;
  endfunction

endpackage

// File: rtl/dtfag_addr_gen_if.sv
// Control, ROM address and data-word bundle between the address generator and its neighbours.
interface dtfag_addr_gen_if #(
  parameter int unsigned D_WIDTH = 128,
  parameter int unsigned LOG_N   = 16
);
  localparam int unsigned AW = LOG_N / 2;

  logic               start;
  logic [1:0]         stage;
  logic               en;
  logic [D_WIDTH-1:0] D_in0, D_in1, D_in2, D_in3;
  logic               busy;
  logic               done;
  logic [AW-1:0]      ROM0_B0_HA_addr, ROM0_B0_LA_addr;
  logic [AW-1:0]      ROM0_B1_HA_addr, ROM0_B1_LA_addr;
  logic               addr_valid;
  logic [D_WIDTH-1:0] D_out0, D_out1, D_out2, D_out3;
  logic               D_out_valid;
  logic [LOG_N-1:0]   grp_idx;

  modport master (
    output start, stage, en, D_in0, D_in1, D_in2, D_in3,
    input  busy, done, ROM0_B0_HA_addr, ROM0_B0_LA_addr, ROM0_B1_HA_addr,
           ROM0_B1_LA_addr, addr_valid, D_out0, D_out1, D_out2, D_out3,
           D_out_valid, grp_idx
  );

  modport slave (
    input  start, stage, en, D_in0, D_in1, D_in2, D_in3,
    output busy, done, ROM0_B0_HA_addr, ROM0_B0_LA_addr, ROM0_B1_HA_addr,
           ROM0_B1_LA_addr, addr_valid, D_out0, D_out1, D_out2, D_out3,
           D_out_valid, grp_idx
  );

endinterface

// File: rtl/dtfag_delay_pipe.sv
// Enable-gated register chain of DEPTH stages; aligns data with synchronous ROM reads.
module dtfag_delay_pipe #(
  parameter int unsigned W     = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] stg [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) stg[i] <= '0;
    end else if (en) begin
      stg[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
    end
  end

  assign dout = stg[DEPTH-1];

endmodule

// File: rtl/dtfag_addr_gen.sv
// Group-index walker and twiddle ROM address generator for one radix-16 FFT stage.
// Define DTFAG_DIGITREV_EN to digit-reverse the group index before exponent formation.
module dtfag_addr_gen #(
  parameter int unsigned D_WIDTH = 128,
  parameter int unsigned LOG_N   = 16,
  parameter int unsigned N_GROUP = 4096,
  parameter int unsigned ROM_LAT = 1
) (
  input logic              clk,
  input logic              rst_n,
  dtfag_addr_gen_if.slave  bus
);
  import dtfag_pkg::*;

  localparam int unsigned AW    = LOG_N / 2;
  localparam int unsigned PW    = 4 * D_WIDTH + 1;
  localparam int unsigned CNT_W = 2;
  localparam logic [LOG_N-1:0] LAST = LOG_N'(N_GROUP - 1);

  fsm_t             state_q, state_d;
  logic [LOG_N-1:0] j_q, j_d, jp, b, e1;
  logic [1:0]       stage_q, stage_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             issue, done_d;

  logic             busy_q, done_q, av_q;
  logic [LOG_N-1:0] grp_q;
  logic [AW-1:0]    b0_ha_q, b0_la_q, b1_ha_q, b1_la_q;
  logic [PW-1:0]    pin, pout;

`ifdef DTFAG_DIGITREV_EN
  localparam int unsigned NDIG = $clog2(N_GROUP) / DIGIT_W;
  assign jp = LOG_N'(digit_rev(exp_t'(j_q), NDIG));
`else
  assign jp = j_q;
`endif

  // Exponents wrap mod 2^LOG_N; the shift drops overflow digits.
  assign b  = LOG_N'(jp << (DIGIT_W * 32'(stage_q)));
  assign e1 = LOG_N'(b << 1);

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    issue   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          stage_d = bus.stage;
          j_d     = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.en) begin
          issue = 1'b1;
          if (j_q == LAST) begin
            cnt_d   = '0;
            state_d = DRAIN;
          end else begin
            j_d = j_q + LOG_N'(1);
          end
        end
      end
      DRAIN: begin
        // Hold busy through the done pulse so a coincident start is refused.
        if (done_q) begin
          state_d = IDLE;
        end else if (bus.en) begin
          if (cnt_q == CNT_W'(ROM_LAT)) done_d = 1'b1;
          else                          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= IDLE;
      j_q     <= '0;
      stage_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      av_q    <= 1'b0;
      grp_q   <= '0;
      b0_ha_q <= '0;
      b0_la_q <= '0;
      b1_ha_q <= '0;
      b1_la_q <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= done_d;
      av_q    <= issue;
      if (issue) begin
        grp_q   <= j_q;
        b0_ha_q <= b[LOG_N-1:AW];
        b0_la_q <= b[AW-1:0];
        b1_ha_q <= e1[LOG_N-1:AW];
        b1_la_q <= e1[AW-1:0];
      end
    end
  end

  assign pin = {av_q, bus.D_in3, bus.D_in2, bus.D_in1, bus.D_in0};

  dtfag_delay_pipe #(.W(PW), .DEPTH(ROM_LAT)) u_pipe (
    .clk  (clk),
    .rst  (rst_n),
    .en   (bus.en),
    .din  (pin),
    .dout (pout)
  );

  assign {bus.D_out_valid, bus.D_out3, bus.D_out2, bus.D_out1, bus.D_out0} = pout;

  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.addr_valid      = av_q;
  assign bus.grp_idx         = grp_q;
  assign bus.ROM0_B0_HA_addr = b0_ha_q;
  assign bus.ROM0_B0_LA_addr = b0_la_q;
  assign bus.ROM0_B1_HA_addr = b1_ha_q;
  assign bus.ROM0_B1_LA_addr = b1_la_q;

endmodule

// File: tb/tb_dtfag_addr_gen.sv
// Directed bench for dtfag_addr_gen: address split, stall, abort and full-sweep timing.
module tb_dtfag_addr_gen;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  dtfag_addr_gen_if #(.D_WIDTH(128), .LOG_N(16)) bus ();

  dtfag_addr_gen #(.D_WIDTH(128), .LOG_N(16), .N_GROUP(4096), .ROM_LAT(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, sample point is 1ns after the edge; fresh data words each cycle.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    bus.D_in0 = {8'h10, 88'h0, 32'(cyc)};
    bus.D_in1 = {8'h11, 88'h0, 32'(cyc)};
    bus.D_in2 = {8'h12, 88'h0, 32'(cyc)};
    bus.D_in3 = {8'h13, 88'h0, 32'(cyc)};
  endtask

  task automatic do_start(input logic [1:0] stg);
    bus.stage = stg;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_grp(input logic [15:0] tgt, input int budget, input string tag);
    int hit;
    hit = 0;
    for (int i = 0; i < budget && hit == 0; i++) begin
      step();
      if (bus.addr_valid === 1'b1 && bus.grp_idx === tgt) hit = 1;
    end
    check(tag, 128'(hit), 128'd1);
  endtask

  task automatic check_addr(input string tag, input logic [7:0] b0h, input logic [7:0] b0l,
                            input logic [7:0] b1h, input logic [7:0] b1l);
    check({tag, "_b0_ha"}, 128'(bus.ROM0_B0_HA_addr), 128'(b0h));
    check({tag, "_b0_la"}, 128'(bus.ROM0_B0_LA_addr), 128'(b0l));
    check({tag, "_b1_ha"}, 128'(bus.ROM0_B1_HA_addr), 128'(b1h));
    check({tag, "_b1_la"}, 128'(bus.ROM0_B1_LA_addr), 128'(b1l));
  endtask

  task automatic reset_pulse();
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
  endtask

  initial begin
    logic [127:0] d0_save;
    int av_cnt, dv_cnt, last_dv, done_cyc, done_cnt;

    rst_n     = 1'b1;
    bus.start = 1'b0;
    bus.en    = 1'b0;
    bus.stage = 2'd0;
    bus.D_in0 = '0;
    bus.D_in1 = '0;
    bus.D_in2 = '0;
    bus.D_in3 = '0;
    repeat (3) step();
    rst_n = 1'b0;

    check("rst_busy",   128'(bus.busy),        128'd0);
    check("rst_done",   128'(bus.done),        128'd0);
    check("rst_av",     128'(bus.addr_valid),  128'd0);
    check("rst_grp",    128'(bus.grp_idx),     128'd0);
    check("rst_dv",     128'(bus.D_out_valid), 128'd0);
    check("rst_dout0",  bus.D_out0,            128'd0);
    check_addr("rst", 8'h00, 8'h00, 8'h00, 8'h00);

    // Stage 0: j=3 address split and one-cycle data delay.
    bus.en = 1'b1;
    do_start(2'd0);
    check("s0_busy", 128'(bus.busy), 128'd1);
    wait_grp(16'd3, 20, "s0_wait_j3");
    check_addr("s0_j3", 8'h00, 8'h03, 8'h00, 8'h06);
    d0_save = bus.D_in0;
    step();
    check("s0_dout0", bus.D_out0, d0_save);
    check("s0_dv",    128'(bus.D_out_valid), 128'd1);

    // Stall three cycles while j=10 is pending; a start pulse meanwhile is ignored.
    wait_grp(16'd9, 20, "s0_wait_j9");
    d0_save   = bus.D_out0;
    bus.en    = 1'b0;
    bus.start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      bus.start = 1'b0;
      check("stall_av",    128'(bus.addr_valid), 128'd0);
      check("stall_grp",   128'(bus.grp_idx),    128'd9);
      check("stall_b0_la", 128'(bus.ROM0_B0_LA_addr), 128'h09);
      check("stall_b1_la", 128'(bus.ROM0_B1_LA_addr), 128'h12);
      check("stall_dout0", bus.D_out0, d0_save);
      check("stall_busy",  128'(bus.busy), 128'd1);
    end
    bus.en = 1'b1;
    step();
    check("resume_av",  128'(bus.addr_valid), 128'd1);
    check("resume_grp", 128'(bus.grp_idx),    128'd10);
    check_addr("resume", 8'h00, 8'h0A, 8'h00, 8'h14);

    // Abort at j=100.
    wait_grp(16'd100, 200, "s0_wait_j100");
    reset_pulse();
    check("abort_av",    128'(bus.addr_valid),  128'd0);
    check("abort_busy",  128'(bus.busy),        128'd0);
    check("abort_done",  128'(bus.done),        128'd0);
    check("abort_grp",   128'(bus.grp_idx),     128'd0);
    check("abort_dv",    128'(bus.D_out_valid), 128'd0);
    check("abort_dout0", bus.D_out0,            128'd0);
    check_addr("abort", 8'h00, 8'h00, 8'h00, 8'h00);
    step();
    check("abort_idle_busy", 128'(bus.busy), 128'd0);
    check("abort_idle_done", 128'(bus.done), 128'd0);

    // Stage 1: j=0x123 -> e0=0x1230, e1=0x2460.
    do_start(2'd1);
    wait_grp(16'h123, 400, "s1_wait");
    check_addr("s1_j123", 8'h12, 8'h30, 8'h24, 8'h60);
    reset_pulse();

    // Stage 2: j=0xABC wraps -> e0=0xBC00, e1=0x7800.
    do_start(2'd2);
    wait_grp(16'hABC, 3000, "s2_wait");
    check_addr("s2_jabc", 8'hBC, 8'h00, 8'h78, 8'h00);
    reset_pulse();

    // Stage 3 full sweep: 4096 issues, done one cycle after the last D_out_valid.
    do_start(2'd3);
    av_cnt   = 0;
    dv_cnt   = 0;
    last_dv  = -1;
    done_cyc = -1;
    done_cnt = 0;
    for (int i = 0; i < 5000 && done_cnt == 0; i++) begin
      step();
      if (bus.addr_valid === 1'b1) av_cnt++;
      if (bus.addr_valid === 1'b1 && bus.grp_idx === 16'd5)
        check_addr("s3_j5", 8'h50, 8'h00, 8'hA0, 8'h00);
      if (bus.D_out_valid === 1'b1) begin
        dv_cnt++;
        last_dv = cyc;
      end
      if (bus.done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
        check("s3_busy_at_done", 128'(bus.busy), 128'd1);
      end
    end
    check("s3_av_count",  128'(av_cnt),   128'd4096);
    check("s3_dv_count",  128'(dv_cnt),   128'd4096);
    check("s3_done_seen", 128'(done_cnt), 128'd1);
    check("s3_done_time", 128'(done_cyc), 128'(last_dv + 1));

    // Start coinciding with done is refused.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("post_busy", 128'(bus.busy),       128'd0);
    check("post_done", 128'(bus.done),       128'd0);
    check("post_av",   128'(bus.addr_valid), 128'd0);
    step();
    check("post_idle_busy", 128'(bus.busy), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
